// File: rtl/elastic_pipe_reg_pkg.sv
// Shared helpers for the elastic pipeline blocks: width sizing and handshake fire.
package elastic_pipe_reg_pkg;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic logic hs_fire(input logic vld, input logic rdy);
    return vld & rdy;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One valid+data pipeline stage: loads on load_i, clear_i drops valid but keeps data.
module pipe_stage_reg #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  // Data only moves with a valid word, so bubbles never overwrite held payload.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (clear_i) begin
      vld_d = 1'b0;
    end else if (load_i) begin
      vld_d = vld_i;
      if (vld_i) dat_d = dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      vld_q <= 1'b0;
      dat_q <= RESET_VAL;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// DEPTH-stage valid/ready pipeline register with bubble collapse, flush and occupancy count.
// in_ready is combinational from out_ready through the per-stage ready chain.
module elastic_pipe_reg
  import elastic_pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        out_ready,
  output logic [clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = clog2(DEPTH + 1);

  logic [DEPTH-1:0] stg_vld;
  logic [WIDTH-1:0] stg_dat [DEPTH];
  logic [DEPTH:0]   stg_rdy;
  logic [DEPTH-1:0] ld_vld;
  logic [WIDTH-1:0] ld_dat [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             accept, emit;

  // A stage can take new contents when it is empty or its occupant moves on.
  always_comb begin
    stg_rdy        = '0;
    stg_rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      stg_rdy[i] = ~stg_vld[i] | stg_rdy[i+1];
    end
  end

  always_comb begin
    ld_vld[0] = in_valid & ~flush;
    ld_dat[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      ld_vld[i] = stg_vld[i-1];
      ld_dat[i] = stg_dat[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_stage_reg #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_stage (
      .clk_i    (clk),
      .reset_n_i(reset_n),
      .clear_i  (flush),
      .load_i   (stg_rdy[g]),
      .vld_i    (ld_vld[g]),
      .dat_i    (ld_dat[g]),
      .vld_o    (stg_vld[g]),
      .dat_o    (stg_dat[g])
    );
  end

  assign in_ready  = stg_rdy[0] & ~flush;
  assign out_valid = stg_vld[DEPTH-1];
  assign out_data  = stg_dat[DEPTH-1];
  assign accept    = hs_fire(in_valid, in_ready);
  assign emit      = hs_fire(out_valid, out_ready);

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (accept && !emit) begin
      count_d = count_q + CW'(1);
    end else if (emit && !accept) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: DEPTH=2 and DEPTH=3 instances against a queue-of-positions model.
module tb_elastic_pipe_reg;

  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n   [2];
  logic        flush     [2];
  logic        in_valid  [2];
  logic [31:0] in_data   [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic [31:0] out_data  [2];
  logic        out_ready [2];
  logic [1:0]  count     [2];

  elastic_pipe_reg #(.WIDTH(32), .DEPTH(2), .RESET_VAL(RV)) u_d2 (
    .clk(clk), .reset_n(reset_n[0]), .flush(flush[0]), .in_valid(in_valid[0]),
    .in_data(in_data[0]), .in_ready(in_ready[0]), .out_valid(out_valid[0]),
    .out_data(out_data[0]), .out_ready(out_ready[0]), .count(count[0])
  );

  elastic_pipe_reg #(.WIDTH(32), .DEPTH(3), .RESET_VAL(RV)) u_d3 (
    .clk(clk), .reset_n(reset_n[1]), .flush(flush[1]), .in_valid(in_valid[1]),
    .in_data(in_data[1]), .in_ready(in_ready[1]), .out_valid(out_valid[1]),
    .out_data(out_data[1]), .out_ready(out_ready[1]), .count(count[1])
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: ordered list of held words (oldest first) with the stage each occupies.
  int          m_n    [2];
  int          m_pos  [2][4];
  logic [31:0] m_dat  [2][4];
  int          m_np   [2][4];
  bit          m_rdy  [2];
  logic [31:0] m_last [2];

  function automatic int dep(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int k, input bit rn, input bit fl, input bit iv,
                       input logic [31:0] id, input bit orr);
    reset_n[k]   = rn;
    flush[k]     = fl;
    in_valid[k]  = iv;
    in_data[k]   = id;
    out_ready[k] = orr;
  endtask

  // Each word moves one stage forward unless the word ahead still sits right in front of it.
  task automatic plan(input int k);
    int pred;
    pred = dep(k);
    for (int j = 0; j < m_n[k]; j++) begin
      if (j == 0 && m_pos[k][j] == dep(k) - 1 && out_ready[k])
        m_np[k][j] = dep(k);
      else if (m_pos[k][j] + 1 < pred)
        m_np[k][j] = m_pos[k][j] + 1;
      else
        m_np[k][j] = m_pos[k][j];
      pred = m_np[k][j];
    end
    m_rdy[k] = (m_n[k] == 0 || m_np[k][m_n[k]-1] != 0) && !flush[k];
  endtask

  task automatic model_check(input int k);
    bit exp_ov;
    plan(k);
    exp_ov = (m_n[k] > 0) && (m_pos[k][0] == dep(k) - 1);
    check_eq($sformatf("d%0d_in_ready", dep(k)),  32'(in_ready[k]),  32'(m_rdy[k]));
    check_eq($sformatf("d%0d_out_valid", dep(k)), 32'(out_valid[k]), 32'(exp_ov));
    check_eq($sformatf("d%0d_count", dep(k)),     32'(count[k]),     32'(m_n[k]));
    check_eq($sformatf("d%0d_out_data", dep(k)),  out_data[k],       m_last[k]);
  endtask

  task automatic model_commit(input int k);
    int o;
    bit acc;
    o = 0;
    if (!reset_n[k]) begin
      m_n[k]    = 0;
      m_last[k] = RV;
    end else begin
      plan(k);
      acc = in_valid[k] && m_rdy[k];
      if (flush[k]) begin
        m_n[k] = 0;
      end else begin
        for (int j = 0; j < m_n[k]; j++) begin
          if (m_np[k][j] < dep(k)) begin
            m_pos[k][o] = m_np[k][j];
            m_dat[k][o] = m_dat[k][j];
            o++;
          end
        end
        if (acc) begin
          m_pos[k][o] = 0;
          m_dat[k][o] = in_data[k];
          o++;
        end
        m_n[k] = o;
        if (o > 0 && m_pos[k][0] == dep(k) - 1) m_last[k] = m_dat[k][0];
      end
    end
  endtask

  task automatic step();
    #1;
    for (int k = 0; k < 2; k++) model_check(k);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_commit(k);
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) drive(k, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      m_n[k]    = 0;
      m_last[k] = RV;
    end
    #1;
    check_eq("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check_eq("rst_count",     32'(count[0]),     32'd0);
    check_eq("rst_out_data",  out_data[0],       32'hDEAD_BEEF);
    check_eq("rst_in_ready",  32'(in_ready[0]),  32'd1);
    step();

    // Streaming 1..8 through DEPTH=2 with the sink always ready
    drive(1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      drive(0, 1'b1, 1'b0, 1'b1, 32'(c + 1), 1'b1);
      #1;
      if (c >= 2) begin
        check_eq("stream_data",  out_data[0],      32'(c - 1));
        check_eq("stream_count", 32'(count[0]),    32'd2);
        check_eq("stream_valid", 32'(out_valid[0]), 32'd1);
      end
      step();
    end
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (3) step();

    // Backpressure: fill with A, B while the sink stalls
    drive(0, 1'b1, 1'b0, 1'b1, 32'hAAAA_0001, 1'b0); step();
    drive(0, 1'b1, 1'b0, 1'b1, 32'hBBBB_0002, 1'b0); step();
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check_eq("bp_count",    32'(count[0]),    32'd2);
    check_eq("bp_in_ready", 32'(in_ready[0]), 32'd0);
    step();
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    #1; check_eq("bp_first",  out_data[0], 32'hAAAA_0001); step();
    #1; check_eq("bp_second", out_data[0], 32'hBBBB_0002); step();
    #1; check_eq("bp_drained", 32'(out_valid[0]), 32'd0); step();

    // Bubble compaction on DEPTH=3: X, idle, Y with the sink stalled
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1, 1'b1, 1'b0, 1'b1, 32'h0000_00A1, 1'b0); step();
    drive(1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);         step();
    drive(1, 1'b1, 1'b0, 1'b1, 32'h0000_00B2, 1'b0); step();
    drive(1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);         step();
    #1;
    check_eq("bub_count",    32'(count[1]),    32'd2);
    check_eq("bub_in_ready", 32'(in_ready[1]), 32'd1);
    check_eq("bub_head",     out_data[1],      32'h0000_00A1);
    drive(1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    #1; check_eq("bub_x", out_data[1], 32'h0000_00A1); step();
    #1; check_eq("bub_y_no_gap", out_data[1], 32'h0000_00B2);
    check_eq("bub_y_valid", 32'(out_valid[1]), 32'd1); step();
    drive(1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Flush with a pending input C that must never appear
    drive(0, 1'b1, 1'b0, 1'b1, 32'h1111_0001, 1'b0); step();
    drive(0, 1'b1, 1'b0, 1'b1, 32'h2222_0002, 1'b0); step();
    drive(0, 1'b1, 1'b1, 1'b1, 32'hCCCC_CCCC, 1'b0);
    #1;
    check_eq("fl_count_before", 32'(count[0]),    32'd2);
    check_eq("fl_in_ready",     32'(in_ready[0]), 32'd0);
    step();
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    check_eq("fl_count", 32'(count[0]),     32'd0);
    check_eq("fl_valid", 32'(out_valid[0]), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("fl_no_c", 32'(out_valid[0]), 32'd0);
    end

    // Reset while full and the sink is draining
    drive(0, 1'b1, 1'b0, 1'b1, 32'h3333_0003, 1'b0); step();
    drive(0, 1'b1, 1'b0, 1'b1, 32'h4444_0004, 1'b0); step();
    drive(0, 1'b0, 1'b0, 1'b1, 32'h5555_0005, 1'b1); step();
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check_eq("mr_count",    32'(count[0]),     32'd0);
    check_eq("mr_valid",    32'(out_valid[0]), 32'd0);
    check_eq("mr_out_data", out_data[0],       32'hDEAD_BEEF);
    step();

    // Randomised traffic on both depths
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        drive(k, $urandom_range(99) != 0, $urandom_range(31) == 0,
              $urandom_range(9) < 6, $urandom, $urandom_range(9) < 6);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
